// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-FF input synchronizer, mid-bit sampling.
// Ports: clk, rst_n (async low), rx_lane in; rx_data/rx_valid/rx_frame_err/rx_busy out.
module uart_rx #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_lane,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   localparam logic [15:0] HALF_C = 16'(BAUD_DIV / 2 - 1);
   localparam logic [15:0] FULL_C = 16'(BAUD_DIV - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        sync1_q, sync2_q;
   logic        rx_sync;

   // Synchronizer resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_lane;
         sync2_q <= sync1_q;
      end
   end

   assign rx_sync = sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_sync) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (cnt_q == HALF_C) begin
               cnt_d = '0;
               if (!rx_sync) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_C) begin
               shift_d = {rx_sync, shift_q[7:1]};
               cnt_d   = '0;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch
            // a start edge that follows immediately.
            if (cnt_q == FULL_C) begin
               cnt_d = '0;
               if (rx_sync) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         BREAK: begin
            if (rx_sync) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIV=16.
// Frames are built bit by bit from the byte value; received bytes are compared to a queue.
module tb_uart_rx;

   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_lane = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   logic [7:0] vq[$];
   int         vt[$];
   int         ferr_n = 0;
   int         both_n = 0;
   int         long_n = 0;
   logic       prev_v = 1'b0;
   logic       prev_e = 1'b0;

   uart_rx #(.BAUD_DIV(BD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_lane(rx_lane),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Output observer: logs valid pulses and counts error/overlap/width events.
   always @(negedge clk) begin
      if (rx_valid) begin
         vq.push_back(rx_data);
         vt.push_back(cyc);
      end
      if (rx_frame_err) ferr_n++;
      if (rx_valid && rx_frame_err) both_n++;
      if ((rx_valid && prev_v) || (rx_frame_err && prev_e)) long_n++;
      prev_v = rx_valid;
      prev_e = rx_frame_err;
   end

   task automatic clear_mon();
      vq.delete();
      vt.delete();
      ferr_n = 0;
   endtask

   task automatic idle(input int n);
      rx_lane = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one full frame starting at a negedge: start, 8 data LSB first, stop.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic bits[10];
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      bits[9] = stop;
      for (int i = 0; i < 10; i++) begin
         rx_lane = bits[i];
         repeat (BD) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx_lane = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rx_data !== 8'h00) $display("FAIL reset_data got %h want 00", rx_data);
      else passes++;
      checks++;
      if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rx_valid);
      else passes++;
      checks++;
      if (rx_frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", rx_frame_err);
      else passes++;
      rx_lane = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", rx_busy);
      else passes++;
      rx_lane = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      checks++;
      if (rx_busy !== 1'b0) $display("FAIL post_reset_busy got %b want 0", rx_busy);
      else passes++;
   endtask

   task automatic test_single();
      int t0;
      int lat;
      clear_mon();
      t0 = cyc;
      send_frame(8'h55, 1'b1);
      idle(6);
      checks++;
      if (vq.size() != 1) $display("FAIL single_count got %0d want 1", vq.size());
      else passes++;
      checks++;
      if (vq.size() < 1 || vq[0] !== 8'h55) $display("FAIL single_data got %h want 55", rx_data);
      else passes++;
      lat = (vt.size() > 0) ? vt[0] - t0 : -1;
      checks++;
      if (lat < 153 || lat > 155) $display("FAIL single_latency got %0d want 154+-1", lat);
      else passes++;
      checks++;
      if (ferr_n != 0) $display("FAIL single_ferr got %0d want 0", ferr_n);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int gap;
      clear_mon();
      send_frame(8'hA3, 1'b1);
      send_frame(8'h0F, 1'b1);
      idle(6);
      checks++;
      if (vq.size() != 2) $display("FAIL b2b_count got %0d want 2", vq.size());
      else passes++;
      checks++;
      if (vq.size() < 2 || vq[0] !== 8'hA3 || vq[1] !== 8'h0F)
         $display("FAIL b2b_data got %0d bytes last %h want A3,0F", vq.size(), rx_data);
      else passes++;
      gap = (vt.size() > 1) ? vt[1] - vt[0] : -1;
      checks++;
      if (gap != 160) $display("FAIL b2b_gap got %0d want 160", gap);
      else passes++;
   endtask

   task automatic test_glitch();
      logic [7:0] prev;
      logic       saw;
      int         w;
      for (int k = 0; k < 4; k++) begin
         clear_mon();
         prev = rx_data;
         saw = 1'b0;
         w = (k == 0) ? 4 : int'($urandom_range(1, 6));
         rx_lane = 1'b0;
         repeat (w) @(negedge clk);
         rx_lane = 1'b1;
         for (int i = w; i < 15; i++) begin
            if (rx_busy) saw = 1'b1;
            @(negedge clk);
         end
         checks++;
         if (rx_busy !== 1'b0 || (w > 2 && !saw))
            $display("FAIL glitch_busy w=%0d got busy=%b seen=%b want 0,1", w, rx_busy, saw);
         else passes++;
         idle(20);
         checks++;
         if (vq.size() != 0 || ferr_n != 0 || rx_data !== prev)
            $display("FAIL glitch_out w=%0d got v=%0d e=%0d d=%h want 0,0,%h",
                     w, vq.size(), ferr_n, rx_data, prev);
         else passes++;
      end
   endtask

   task automatic test_frame_err();
      logic [7:0] prev;
      clear_mon();
      prev = rx_data;
      send_frame(8'h3C, 1'b0);
      rx_lane = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b1) $display("FAIL break_busy got %b want 1", rx_busy);
      else passes++;
      idle(10);
      checks++;
      if (ferr_n != 1) $display("FAIL ferr_count got %0d want 1", ferr_n);
      else passes++;
      checks++;
      if (vq.size() != 0 || rx_data !== prev)
         $display("FAIL ferr_data got v=%0d d=%h want 0,%h", vq.size(), rx_data, prev);
      else passes++;
      send_frame(8'h81, 1'b1);
      idle(6);
      checks++;
      if (vq.size() != 1 || vq[0] !== 8'h81)
         $display("FAIL after_err got %0d bytes d=%h want 81", vq.size(), rx_data);
      else passes++;
   endtask

   task automatic test_reset_mid();
      clear_mon();
      rx_lane = 1'b0;
      repeat (BD) @(negedge clk);
      rx_lane = 1'b1;
      repeat (4 * BD + BD / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (rx_busy !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0)
         $display("FAIL midreset_out got b=%b d=%h v=%b e=%b want 0,00,0,0",
                  rx_busy, rx_data, rx_valid, rx_frame_err);
      else passes++;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      idle(5 * BD);
      checks++;
      if (vq.size() != 0 || ferr_n != 0)
         $display("FAIL midreset_abort got v=%0d e=%0d want 0,0", vq.size(), ferr_n);
      else passes++;
      send_frame(8'h42, 1'b1);
      idle(6);
      checks++;
      if (vq.size() != 1 || vq[0] !== 8'h42 || ferr_n != 0)
         $display("FAIL midreset_next got %0d bytes d=%h e=%0d want 42", vq.size(), rx_data, ferr_n);
      else passes++;
   endtask

   task automatic test_sweep();
      int         ord[256];
      int         j;
      int         t;
      logic [7:0] exp_q[$];
      for (int i = 0; i < 256; i++) ord[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = int'($urandom_range(0, i));
         t = ord[i];
         ord[i] = ord[j];
         ord[j] = t;
      end
      clear_mon();
      for (int i = 0; i < 256; i++) begin
         exp_q.push_back(8'(ord[i]));
         send_frame(8'(ord[i]), 1'b1);
         idle(int'($urandom_range(0, 3)));
      end
      idle(6);
      checks++;
      if (vq.size() != 256) $display("FAIL sweep_count got %0d want 256", vq.size());
      else passes++;
      for (int i = 0; i < 256; i++) begin
         checks++;
         if (i >= vq.size() || vq[i] !== exp_q[i])
            $display("FAIL sweep_byte[%0d] got %h want %h", i,
                     (i < vq.size()) ? vq[i] : 8'hxx, exp_q[i]);
         else passes++;
      end
      checks++;
      if (ferr_n != 0) $display("FAIL sweep_ferr got %0d want 0", ferr_n);
      else passes++;
   endtask

   task automatic test_pulse_shape();
      checks++;
      if (both_n != 0) $display("FAIL pulse_overlap got %0d want 0", both_n);
      else passes++;
      checks++;
      if (long_n != 0) $display("FAIL pulse_width got %0d want 0", long_n);
      else passes++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_sweep();
      test_pulse_shape();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
